radiance_minmax_scan: RTL and testbench

- Upstream statistics stage for the global tone-mapping stage.
- Streams the radiance frame out of the shared single-port pixel RAM and tracks the unsigned minimum and maximum pixel values.
- Publishes min, max and a divide-safe range (max-min, never 0), then raises a done flag.
- The downstream stage takes o_rad_min and o_rad_maxmin directly and uses o_fin as its i_start.

---
 rtl/radiance_minmax_scan_if.sv | 19 +
 rtl/radiance_minmax_scan.sv | 128 ++++++++++++
 tb/tb_radiance_minmax_scan.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/radiance_minmax_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : radiance_minmax_scan_if
// Description : Read-only pixel RAM bus between the min/max scanner (master)
//               and the shared single-port pixel RAM (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface radiance_minmax_scan_if #(
  parameter int ADDR_W = 20,
  parameter int D_W    = 16
);
  logic [ADDR_W-1:0] o_addr;
  logic              o_ren;
  logic [D_W-1:0]    i_rdata;

  modport master (output o_addr, output o_ren, input  i_rdata);
  modport slave  (input  o_addr, input  o_ren, output i_rdata);
endinterface
`default_nettype wire

// File: rtl/radiance_minmax_scan.sv
`default_nettype none
// ============================================================================
// Module      : radiance_minmax_scan
// Description : Streams a radiance frame out of the pixel RAM, tracks the
//               unsigned min/max and publishes min, max and a divide-safe
//               range (never 0) for the tone-mapping stage.
// Revision    : 1.0 - initial release
// ============================================================================
module radiance_minmax_scan #(
  parameter int D_W    = 16,
  parameter int ADDR_W = 20,
  parameter int NUM_W  = 20
) (
  input  wire logic                i_clk,
  input  wire logic                rst_n,
  input  wire logic                i_start,
  input  wire logic [NUM_W-1:0]    total_pixels,
  radiance_minmax_scan_if.master   ram,
  output logic      [D_W-1:0]      o_rad_min,
  output logic      [D_W-1:0]      o_rad_max,
  output logic      [D_W-1:0]      o_rad_maxmin,
  output logic                     o_busy,
  output logic                     o_fin
);

  localparam logic [D_W-1:0] c_RANGE_ONE = {{(D_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_DRAIN = 3'd2,
    S_CALC  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic [NUM_W-1:0]  r_n;
  logic [NUM_W-1:0]  r_ctr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rvalid;
  logic [D_W-1:0]    r_min;
  logic [D_W-1:0]    r_max;

  // A start is only honoured while idle or parked in S_FIN.
  assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_FIN));

  assign ram.o_addr = r_addr;
  assign ram.o_ren  = (r_state == S_SCAN);
  assign o_busy     = (r_state == S_SCAN) || (r_state == S_DRAIN) || (r_state == S_CALC);
  assign o_fin      = (r_state == S_FIN);

  // State register.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; an empty frame skips the scan and goes straight to CALC.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (w_accept) w_state_nxt = (total_pixels == '0) ? S_CALC : S_SCAN;
      end
      S_SCAN:  if (r_ctr >= r_n) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_FIN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address generator: one read per cycle, address parks at N-1 afterwards.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n      <= '0;
      r_ctr    <= '0;
      r_addr   <= '0;
      r_rvalid <= 1'b0;
    end else if (w_accept) begin
      r_n      <= total_pixels;
      r_rvalid <= 1'b0;
      if (total_pixels != '0) begin
        r_addr <= '0;
        r_ctr  <= {{(NUM_W-1){1'b0}}, 1'b1};
      end
    end else if (r_state == S_SCAN) begin
      // Data for the address presented this cycle arrives next cycle.
      r_rvalid <= 1'b1;
      if (r_ctr < r_n) begin
        r_addr <= r_addr + 1'b1;
        r_ctr  <= r_ctr + 1'b1;
      end
    end else if (r_state == S_DRAIN) begin
      r_rvalid <= 1'b0;
    end
  end

  // Running min/max; min seeds at all-ones so the first pixel updates both.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '0;
      r_max <= '0;
    end else if (w_accept) begin
      r_min <= (total_pixels == '0) ? '0 : '1;
      r_max <= '0;
    end else if (r_rvalid) begin
      if (ram.i_rdata < r_min) r_min <= ram.i_rdata;
      if (ram.i_rdata > r_max) r_max <= ram.i_rdata;
    end
  end

  // Publish results once per frame; they hold across a restart.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rad_min    <= '0;
      o_rad_max    <= '0;
      o_rad_maxmin <= '0;
    end else if (r_state == S_CALC) begin
      o_rad_min    <= r_min;
      o_rad_max    <= r_max;
      o_rad_maxmin <= (r_max == r_min) ? c_RANGE_ONE : (r_max - r_min);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_radiance_minmax_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_radiance_minmax_scan
// Description : Self-checking bench for radiance_minmax_scan with a
//               frame-level timeline model and directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radiance_minmax_scan;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [19:0] total_pixels;
  logic [15:0] o_rad_min, o_rad_max, o_rad_maxmin;
  logic        o_busy, o_fin;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:15];

  radiance_minmax_scan_if #(.ADDR_W(20), .D_W(16)) ram ();

  radiance_minmax_scan #(.D_W(16), .ADDR_W(20), .NUM_W(20)) dut (
    .i_clk        (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .total_pixels (total_pixels),
    .ram          (ram),
    .o_rad_min    (o_rad_min),
    .o_rad_max    (o_rad_max),
    .o_rad_maxmin (o_rad_maxmin),
    .o_busy       (o_busy),
    .o_fin        (o_fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data one cycle after address/strobe.
  always @(posedge clk) begin
    if (ram.o_ren) ram.i_rdata <= mem[ram.o_addr[3:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  bit          m_busy, m_fin;
  int          m_k, m_n, m_done;
  logic [19:0] e_addr;
  logic [15:0] e_min, e_max, e_mm;
  logic [15:0] f_min, f_max;

  task automatic model_reset();
    m_busy = 0; m_fin = 0; m_k = 0; m_n = 0; m_done = 0;
    e_addr = '0; e_min = '0; e_max = '0; e_mm = '0;
  endtask

  initial model_reset();
  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      if (!m_busy && i_start) begin
        m_n    = int'(total_pixels);
        m_k    = 0;
        m_busy = 1;
        m_fin  = 0;
        m_done = (m_n == 0) ? 1 : m_n + 2;
        if (m_n > 0) e_addr = '0;
        // Frame statistics straight from the frame contents.
        f_min = (m_n == 0) ? 16'd0 : 16'hFFFF;
        f_max = 16'd0;
        for (int i = 0; i < m_n; i++) begin
          if (mem[i] < f_min) f_min = mem[i];
          if (mem[i] > f_max) f_max = mem[i];
        end
      end else if (m_busy) begin
        m_k++;
        if (m_k < m_n) e_addr = 20'(m_k);
        if (m_k == m_done) begin
          e_min  = f_min;
          e_max  = f_max;
          e_mm   = (f_max == f_min) ? 16'd1 : f_max - f_min;
          m_busy = 0;
          m_fin  = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("ren",    {31'd0, ram.o_ren}, {31'd0, (m_busy && m_n > 0 && m_k < m_n)});
    check("addr",   {12'd0, ram.o_addr}, {12'd0, e_addr});
    check("busy",   {31'd0, o_busy}, {31'd0, m_busy});
    check("fin",    {31'd0, o_fin},  {31'd0, m_fin});
    check("min",    {16'd0, o_rad_min},    {16'd0, e_min});
    check("max",    {16'd0, o_rad_max},    {16'd0, e_max});
    check("maxmin", {16'd0, o_rad_maxmin}, {16'd0, e_mm});
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input int n);
    @(negedge clk); #2;
    total_pixels = 20'(n);
    i_start = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
    check("fin_drop", {31'd0, o_fin}, 32'd0);
  endtask

  task automatic wait_fin(input int exp_edges);
    int edges = 0;
    while (!o_fin && edges < 100) begin
      @(posedge clk); edges++; #1;
    end
    check("fin_latency", edges, exp_edges);
  endtask

  task automatic expect_pub(input logic [15:0] mn, input logic [15:0] mx, input logic [15:0] mm);
    check("lit_min",    {16'd0, o_rad_min},    {16'd0, mn});
    check("lit_max",    {16'd0, o_rad_max},    {16'd0, mx});
    check("lit_maxmin", {16'd0, o_rad_maxmin}, {16'd0, mm});
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; total_pixels = '0;
    for (int i = 0; i < 16; i++) mem[i] = 16'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_fin",  {31'd0, o_fin}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    expect_pub(16'd0, 16'd0, 16'd0);
    #1 rst_n = 1'b1;

    // Frame of four distinct pixels.
    mem[0] = 16'd40; mem[1] = 16'd10; mem[2] = 16'd250; mem[3] = 16'd90;
    start_frame(4);
    wait_fin(6);
    expect_pub(16'd10, 16'd250, 16'd240);
    check("lit_addr_park", {12'd0, ram.o_addr}, 32'd3);

    // Flat frame exercises the zero-range guard.
    for (int i = 0; i < 3; i++) mem[i] = 16'd77;
    start_frame(3);
    wait_fin(5);
    expect_pub(16'd77, 16'd77, 16'd1);

    // Empty frame.
    start_frame(0);
    wait_fin(1);
    expect_pub(16'd0, 16'd0, 16'd1);

    // Single all-ones pixel.
    mem[0] = 16'hFFFF;
    start_frame(1);
    wait_fin(3);
    expect_pub(16'hFFFF, 16'hFFFF, 16'd1);

    // Mid-scan restart attempt, size change, then abort by reset.
    mem[0] = 16'd8; mem[1] = 16'd3; mem[2] = 16'd9; mem[3] = 16'd1;
    mem[4] = 16'd7; mem[5] = 16'd2; mem[6] = 16'd6; mem[7] = 16'd5;
    start_frame(8);
    @(posedge clk); #2;
    total_pixels = 20'd2;
    i_start = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
    check("busy_ignores_start", {31'd0, o_busy}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_ren",  {31'd0, ram.o_ren}, 32'd0);
    check("abort_addr", {12'd0, ram.o_addr}, 32'd0);
    expect_pub(16'd0, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    start_frame(8);
    wait_fin(10);
    expect_pub(16'd1, 16'd9, 16'd8);

    // Back-to-back: start held high while parked in FIN.
    mem[0] = 16'd5; mem[1] = 16'd300;
    start_frame(2);
    check("b2b_busy", {31'd0, o_busy}, 32'd1);
    expect_pub(16'd1, 16'd9, 16'd8);
    wait_fin(4);
    expect_pub(16'd5, 16'd300, 16'd295);

    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
